// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
//
// Purpose:
//   Brings a PLL out of reset and supervises its lock. The PLL is pulsed into
//   reset, given a bounded time to lock, and its lock must then hold for a
//   qualification window before the downstream core is released. If lock is
//   lost while running, the core goes back into reset and the PLL is pulsed
//   again. If lock never arrives after all retries, the block parks in FAIL
//   until the next rst.
//
// Ports:
//   refclk      in   sole clock, all logic on the rising edge
//   rst         in   asynchronous, active-high reset
//   pll_locked  in   PLL lock flag, asynchronous to refclk
//   pll_rst     out  PLL reset, active-high (high only in PULSE)
//   sys_reset   out  downstream core reset, active-high (low only in RUN)
//   ready       out  high only in RUN
//   fail        out  high only in FAIL
//   relock_cnt  out  lock losses seen in RUN, saturates at 255
//
// Configuration:
//   PLL_SUPERVISOR_RELOCK_COUNT_EN  defined   -> relock_cnt counter built
//                                   undefined -> relock_cnt tied to zero
// -----------------------------------------------------------------------------
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 7
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic       fail,
  output logic [7:0] relock_cnt
);

  // One phase counter is shared by PULSE, WAIT_LOCK and STABLE; it is sized
  // for the largest terminal value so it never wraps before terminal count.
  localparam int unsigned MAX_PT  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                    RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_PT > LOCK_STABLE_CYCLES) ?
                                    MAX_PT : LOCK_STABLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  // STABLE spends its entry cycle clearing the counter, then needs
  // LOCK_STABLE_CYCLES further locked cycles before RUN.
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES);
  localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PULSE,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_q, retry_d;
  logic             locked_meta_q, locked_meta_d;
  logic             locked_s_q, locked_s_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_reset_q, sys_reset_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    retry_d       = retry_q;
    locked_meta_d = pll_locked;
    locked_s_d    = locked_meta_q;

    case (state_q)
      S_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        // Lock seen in the timeout cycle still wins over the timeout.
        if (locked_s_q) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d = '0;
          if (retry_q < RETRY_LIMIT) begin
            retry_d = retry_q + 8'd1;
            state_d = S_PULSE;
          end else begin
            state_d = S_FAIL;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STABLE: begin
        // A glitch in lock costs only the qualification window, not a new
        // PLL reset, and does not consume a retry.
        if (!locked_s_q) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (!locked_s_q) begin
          state_d = S_PULSE;
          cnt_d   = '0;
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_PULSE;
        cnt_d   = '0;
      end
    endcase

    // Outputs decoded from the next state so they change on the entry edge.
    pll_rst_d   = (state_d == S_PULSE);
    sys_reset_d = (state_d != S_RUN);
    ready_d     = (state_d == S_RUN);
    fail_d      = (state_d == S_FAIL);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q       <= S_PULSE;
      cnt_q         <= '0;
      retry_q       <= '0;
      locked_meta_q <= 1'b0;
      locked_s_q    <= 1'b0;
      pll_rst_q     <= 1'b1;
      sys_reset_q   <= 1'b1;
      ready_q       <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      locked_meta_q <= locked_meta_d;
      locked_s_q    <= locked_s_d;
      pll_rst_q     <= pll_rst_d;
      sys_reset_q   <= sys_reset_d;
      ready_q       <= ready_d;
      fail_q        <= fail_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_reset = sys_reset_q;
  assign ready     = ready_q;
  assign fail      = fail_q;

`ifdef PLL_SUPERVISOR_RELOCK_COUNT_EN
  logic [7:0] relock_q, relock_d;

  // Counts on the same edge RUN is left for PULSE; holds at 255.
  always_comb begin
    relock_d = relock_q;
    if ((state_q == S_RUN) && !locked_s_q && (relock_q != 8'hFF)) begin
      relock_d = relock_q + 8'd1;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      relock_q <= '0;
    end else begin
      relock_q <= relock_d;
    end
  end

  assign relock_cnt = relock_q;
`else
  assign relock_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_supervisor
//
// Purpose:
//   Directed bench for pll_lock_supervisor built with RST_PULSE_CYCLES=4,
//   LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2. Expected
//   output words {pll_rst, sys_reset, ready, fail} are hand-derived per edge
//   after rst release (edge 1 is the first rising edge after release).
//   Honours PLL_SUPERVISOR_RELOCK_COUNT_EN for relock_cnt expectations.
// -----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

`ifdef PLL_SUPERVISOR_RELOCK_COUNT_EN
  localparam bit RELOCK_EN = 1'b1;
`else
  localparam bit RELOCK_EN = 1'b0;
`endif

  // {pll_rst, sys_reset, ready, fail}
  localparam logic [3:0] O_PULSE = 4'b1100;
  localparam logic [3:0] O_WAIT  = 4'b0100;  // WAIT_LOCK and STABLE
  localparam logic [3:0] O_RUN   = 4'b0010;
  localparam logic [3:0] O_FAIL  = 4'b0101;

  logic       refclk = 1'b0;
  logic       rst = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic       fail;
  logic [7:0] relock_cnt;
  logic [3:0] outs;

  int vectors = 0;
  int miscompares = 0;

  assign outs = {pll_rst, sys_reset, ready, fail};

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES(20),
    .LOCK_STABLE_CYCLES (8),
    .MAX_RETRIES        (2)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .pll_rst   (pll_rst),
    .sys_reset (sys_reset),
    .ready     (ready),
    .fail      (fail),
    .relock_cnt(relock_cnt)
  );

  always #5 refclk = ~refclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish long before");
    $fatal(1);
  end

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // Holds rst across two edges, then releases it 1 time unit after an edge.
  task automatic do_reset(input logic lk);
    rst = 1'b1;
    pll_locked = lk;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    #1 rst = 1'b1;
    #2;
    vectors++;
    if (outs !== O_PULSE) begin
      miscompares++;
      $display("FAIL reset_async outs: got %b want %b", outs, O_PULSE);
    end
    vectors++;
    if (relock_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_async relock_cnt: got %0d want 0", relock_cnt);
    end
    repeat (3) tick();
    vectors++;
    if (outs !== O_PULSE) begin
      miscompares++;
      $display("FAIL reset_held outs: got %b want %b", outs, O_PULSE);
    end
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp = (i < 4) ? O_PULSE : O_WAIT;
      vectors++;
      if (outs !== exp) begin
        miscompares++;
        $display("FAIL reset_first_pulse edge %0d: got %b want %b", i, outs, exp);
      end
    end
  endtask

  // Lock held throughout: WAIT_LOCK entered at edge 4, RUN at edge 14.
  task automatic test_lock_constant();
    logic [3:0] exp;
    do_reset(1'b1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      exp = (i < 4) ? O_PULSE : (i < 14) ? O_WAIT : O_RUN;
      vectors++;
      if (outs !== exp) begin
        miscompares++;
        $display("FAIL lock_constant edge %0d: got %b want %b", i, outs, exp);
      end
    end
  endtask

  // No lock: pulses at edges 1-3 (+reset), 24-27, 48-51; FAIL from edge 72.
  task automatic test_lock_timeout();
    logic [3:0] exp;
    do_reset(1'b0);
    for (int i = 1; i <= 110; i++) begin
      tick();
      if (i >= 72) exp = O_FAIL;
      else if (i <= 3 || (i >= 24 && i <= 27) || (i >= 48 && i <= 51)) exp = O_PULSE;
      else exp = O_WAIT;
      vectors++;
      if (outs !== exp) begin
        miscompares++;
        $display("FAIL lock_timeout edge %0d: got %b want %b", i, outs, exp);
      end
    end
  endtask

  // Lock drops mid-STABLE (after edge 9) and returns after edge 12: the block
  // goes back to WAIT_LOCK at edge 12 without a PLL pulse, re-enters STABLE at
  // edge 15, and needs the full window again, reaching RUN at edge 24.
  task automatic test_stable_drop();
    logic [3:0] exp;
    do_reset(1'b1);
    for (int i = 1; i <= 25; i++) begin
      tick();
      exp = (i < 4) ? O_PULSE : (i < 24) ? O_WAIT : O_RUN;
      vectors++;
      if (outs !== exp) begin
        miscompares++;
        $display("FAIL stable_drop edge %0d: got %b want %b", i, outs, exp);
      end
      if (i == 9)  pll_locked = 1'b0;
      if (i == 12) pll_locked = 1'b1;
    end
  endtask

  // Three lock losses in RUN; core reset follows each drop by three edges,
  // then a fresh 4-cycle PLL pulse and a 14-edge re-qualification.
  task automatic test_relock();
    logic [3:0] exp;
    logic [7:0] exp_cnt;
    do_reset(1'b1);
    repeat (14) tick();
    vectors++;
    if (outs !== O_RUN) begin
      miscompares++;
      $display("FAIL relock_start outs: got %b want %b", outs, O_RUN);
    end
    for (int k = 1; k <= 3; k++) begin
      pll_locked = 1'b0;
      for (int i = 1; i <= 3; i++) begin
        tick();
        exp = (i < 3) ? O_RUN : O_PULSE;
        vectors++;
        if (outs !== exp) begin
          miscompares++;
          $display("FAIL relock_drop %0d edge %0d: got %b want %b", k, i, outs, exp);
        end
      end
      exp_cnt = RELOCK_EN ? 8'(k) : 8'd0;
      vectors++;
      if (relock_cnt !== exp_cnt) begin
        miscompares++;
        $display("FAIL relock_cnt after loss %0d: got %0d want %0d", k, relock_cnt, exp_cnt);
      end
      pll_locked = 1'b1;
      for (int i = 1; i <= 14; i++) begin
        tick();
        exp = (i < 4) ? O_PULSE : (i < 14) ? O_WAIT : O_RUN;
        vectors++;
        if (outs !== exp) begin
          miscompares++;
          $display("FAIL relock_recover %0d edge %0d: got %b want %b", k, i, outs, exp);
        end
      end
    end
  endtask

  // Called while in RUN: rst mid-RUN, then mid-STABLE, each between edges.
  task automatic test_async_reset();
    logic [3:0] exp;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (outs !== O_PULSE) begin
      miscompares++;
      $display("FAIL async_reset_run outs: got %b want %b", outs, O_PULSE);
    end
    vectors++;
    if (relock_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL async_reset_run relock_cnt: got %0d want 0", relock_cnt);
    end
    tick();
    rst = 1'b0;
    repeat (7) tick();
    vectors++;
    if (outs !== O_WAIT) begin
      miscompares++;
      $display("FAIL async_reset_pre_stable outs: got %b want %b", outs, O_WAIT);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (outs !== O_PULSE) begin
      miscompares++;
      $display("FAIL async_reset_stable outs: got %b want %b", outs, O_PULSE);
    end
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp = (i < 4) ? O_PULSE : O_WAIT;
      vectors++;
      if (outs !== exp) begin
        miscompares++;
        $display("FAIL async_reset_repulse edge %0d: got %b want %b", i, outs, exp);
      end
    end
  endtask

`ifdef PLL_SUPERVISOR_RELOCK_COUNT_EN
  task automatic test_relock_saturate();
    logic [7:0] exp_cnt;
    do_reset(1'b1);
    repeat (14) tick();
    for (int n = 1; n <= 300; n++) begin
      pll_locked = 1'b0;
      repeat (3) tick();
      pll_locked = 1'b1;
      repeat (14) tick();
      if (n == 254 || n == 255 || n == 256 || n == 300) begin
        exp_cnt = (n > 255) ? 8'd255 : 8'(n);
        vectors++;
        if (relock_cnt !== exp_cnt || outs !== O_RUN) begin
          miscompares++;
          $display("FAIL relock_saturate after %0d losses: cnt %0d outs %b want cnt %0d outs %b",
                   n, relock_cnt, outs, exp_cnt, O_RUN);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lock_constant();
    test_lock_timeout();
    test_stable_drop();
    test_relock();
    test_async_reset();
`ifdef PLL_SUPERVISOR_RELOCK_COUNT_EN
    test_relock_saturate();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
